acumulador_soma_sub: RTL and testbench

ACUMULADOR_SOMA_SUB -- requirements
Module: acumulador_soma_sub

---
 rtl/acumulador_pkg.sv | 17 +
 rtl/somador_sub_nb.sv | 14 +
 rtl/acumulador_soma_sub.sv | 181 ++++++++++++++++++
 tb/tb_acumulador_soma_sub.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/acumulador_pkg.sv
// Shared types for the add/subtract accumulator: FSM states and op encodings.
package acumulador_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        SAIDA  = 2'd2
    } estado_t;

    typedef enum logic {
        OP_SOMA = 1'b0,
        OP_SUB  = 1'b1
    } op_t;

    localparam int N_OPS_W = 8;

endpackage

// File: rtl/somador_sub_nb.sv
// Combinational (LARGURA+1)-bit adder/subtractor; bit LARGURA is carry or borrow.
module somador_sub_nb #(
    parameter int LARGURA = 8
) (
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA:0]   soma,
    output logic [LARGURA:0]   dif
);

    assign soma = {1'b0, a} + {1'b0, b};
    assign dif  = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/acumulador_soma_sub.sv
// Handshaked add/subtract accumulator with flags and an operation counter.
// Optional saturation is enabled by defining ACUMULADOR_SATURACAO_EN.
module acumulador_soma_sub
    import acumulador_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [LARGURA-1:0]   dado,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LARGURA-1:0]   acc,
    output logic                 carry,
    output logic                 borrow,
    output logic                 zero,
    output logic [N_OPS_W-1:0]   n_ops
);

    estado_t             state_r;
    estado_t             state_next_s;
    op_t                 op_r;
    logic [LARGURA-1:0]  dado_r;
    logic [LARGURA:0]    soma_s;
    logic [LARGURA:0]    dif_s;
    logic [LARGURA-1:0]  res_acc_s;
    logic                res_carry_s;
    logic                res_borrow_s;

    somador_sub_nb #(
        .LARGURA (LARGURA)
    ) u_somador (
        .a    (acc),
        .b    (dado_r),
        .soma (soma_s),
        .dif  (dif_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= OCIOSO;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; clr forces the idle state from anywhere
    always_comb begin
        state_next_s = state_r;
        if (clr) begin
            state_next_s = OCIOSO;
        end else begin
            case (state_r)
                OCIOSO: begin
                    if (in_valid) begin
                        state_next_s = CALC;
                    end else begin
                        state_next_s = OCIOSO;
                    end
                end
                CALC: begin
                    state_next_s = SAIDA;
                end
                SAIDA: begin
                    if (out_ready) begin
                        state_next_s = OCIOSO;
                    end else begin
                        state_next_s = SAIDA;
                    end
                end
                default: begin
                    state_next_s = OCIOSO;
                end
            endcase
        end
    end

    // FSM outputs decoded from the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            OCIOSO: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            CALC: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
            SAIDA: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Result selection: flags always report the raw carry/borrow, even when saturating
    always_comb begin
        res_acc_s    = {LARGURA{1'b0}};
        res_carry_s  = 1'b0;
        res_borrow_s = 1'b0;
        if (op_r == OP_SUB) begin
            res_carry_s  = 1'b0;
            res_borrow_s = dif_s[LARGURA];
`ifdef ACUMULADOR_SATURACAO_EN
            if (dif_s[LARGURA]) begin
                res_acc_s = {LARGURA{1'b0}};
            end else begin
                res_acc_s = dif_s[LARGURA-1:0];
            end
`else
            res_acc_s = dif_s[LARGURA-1:0];
`endif
        end else begin
            res_carry_s  = soma_s[LARGURA];
            res_borrow_s = 1'b0;
`ifdef ACUMULADOR_SATURACAO_EN
            if (soma_s[LARGURA]) begin
                res_acc_s = {LARGURA{1'b1}};
            end else begin
                res_acc_s = soma_s[LARGURA-1:0];
            end
`else
            res_acc_s = soma_s[LARGURA-1:0];
`endif
        end
    end

    // Operand capture, accumulator, flags and operation counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r   <= OP_SOMA;
            dado_r <= {LARGURA{1'b0}};
            acc    <= {LARGURA{1'b0}};
            carry  <= 1'b0;
            borrow <= 1'b0;
            zero   <= 1'b1;
            n_ops  <= {N_OPS_W{1'b0}};
        end else if (clr) begin
            op_r   <= OP_SOMA;
            dado_r <= {LARGURA{1'b0}};
            acc    <= {LARGURA{1'b0}};
            carry  <= 1'b0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            n_ops  <= {N_OPS_W{1'b0}};
        end else begin
            if ((state_r == OCIOSO) && in_valid) begin
                op_r   <= op_t'(op);
                dado_r <= dado;
            end else begin
                op_r   <= op_r;
                dado_r <= dado_r;
            end
            if (state_r == CALC) begin
                acc    <= res_acc_s;
                carry  <= res_carry_s;
                borrow <= res_borrow_s;
                zero   <= (res_acc_s == {LARGURA{1'b0}});
                n_ops  <= n_ops + {{(N_OPS_W-1){1'b0}}, 1'b1};
            end else begin
                acc    <= acc;
                carry  <= carry;
                borrow <= borrow;
                zero   <= zero;
                n_ops  <= n_ops;
            end
        end
    end

endmodule

// File: tb/tb_acumulador_soma_sub.sv
// Directed self-checking bench for acumulador_soma_sub (default or saturating build).
module tb_acumulador_soma_sub;

    logic       clk = 1'b0;
    logic       rst_n, clr, in_valid, in_ready, op, out_valid, out_ready;
    logic [7:0] dado, acc, n_ops;
    logic       carry, borrow, zero;
    logic       mid_ov, mid_ir;
    logic [7:0] exp_acc;
    logic       exp_zero;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    acumulador_soma_sub #(.LARGURA(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .dado      (dado),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .borrow    (borrow),
        .zero      (zero),
        .n_ops     (n_ops)
    );

    // Starts at a negedge in OCIOSO, ends at the negedge where the result is shown
    task automatic send(input logic o, input logic [7:0] d);
        in_valid = 1'b1;
        op       = o;
        dado     = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        mid_ov = out_valid;
        mid_ir = in_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; op = 1'b0; dado = 8'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (acc !== 8'd0) begin failures++; $display("FAIL rst_acc got=%0d exp=0", acc); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL rst_zero got=%b exp=1", zero); end
        checks++; if ({carry, borrow} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {carry, borrow}); end
        checks++; if (n_ops !== 8'd0) begin failures++; $display("FAIL rst_nops got=%0d exp=0", n_ops); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_ov got=%b exp=0", out_valid); end
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ir got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        send(1'b0, 8'd100);
        checks++; if ({mid_ov, mid_ir} !== 2'b00) begin failures++; $display("FAIL add_latency_calc got=%b exp=00", {mid_ov, mid_ir}); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_latency_ov got=%b exp=1", out_valid); end
        checks++; if (acc !== 8'd100) begin failures++; $display("FAIL add100_acc got=%0d exp=100", acc); end
        checks++; if (n_ops !== 8'd1) begin failures++; $display("FAIL add100_nops got=%0d exp=1", n_ops); end
        step();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL add_return_idle got=%b exp=10", {in_ready, out_valid}); end
        send(1'b0, 8'd50);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add50_ov got=%b exp=1", out_valid); end
        checks++; if (acc !== 8'd150) begin failures++; $display("FAIL add50_acc got=%0d exp=150", acc); end
        checks++; if ({carry, zero} !== 2'b00) begin failures++; $display("FAIL add50_flags got=%b exp=00", {carry, zero}); end
        checks++; if (n_ops !== 8'd2) begin failures++; $display("FAIL add50_nops got=%0d exp=2", n_ops); end
        step();
    endtask

    task automatic test_carry();
        send(1'b0, 8'd50);
        checks++; if (acc !== 8'd200) begin failures++; $display("FAIL pre_carry_acc got=%0d exp=200", acc); end
        step();
        send(1'b0, 8'd100);
`ifdef ACUMULADOR_SATURACAO_EN
        exp_acc = 8'd255;
`else
        exp_acc = 8'd44;
`endif
        checks++; if (acc !== exp_acc) begin failures++; $display("FAIL carry_acc got=%0d exp=%0d", acc, exp_acc); end
        checks++; if ({carry, borrow, zero} !== 3'b100) begin failures++; $display("FAIL carry_flags got=%b exp=100", {carry, borrow, zero}); end
        checks++; if (n_ops !== 8'd4) begin failures++; $display("FAIL carry_nops got=%0d exp=4", n_ops); end
        step();
    endtask

    task automatic test_sub_borrow();
`ifdef ACUMULADOR_SATURACAO_EN
        send(1'b1, 8'd245);
`else
        send(1'b1, 8'd34);
`endif
        checks++; if (acc !== 8'd10) begin failures++; $display("FAIL sub_to10_acc got=%0d exp=10", acc); end
        step();
        send(1'b1, 8'd10);
        checks++; if (acc !== 8'd0) begin failures++; $display("FAIL sub10_acc got=%0d exp=0", acc); end
        checks++; if ({carry, borrow, zero} !== 3'b001) begin failures++; $display("FAIL sub10_flags got=%b exp=001", {carry, borrow, zero}); end
        step();
        send(1'b1, 8'd1);
`ifdef ACUMULADOR_SATURACAO_EN
        exp_acc = 8'd0;   exp_zero = 1'b1;
`else
        exp_acc = 8'd255; exp_zero = 1'b0;
`endif
        checks++; if (acc !== exp_acc) begin failures++; $display("FAIL borrow_acc got=%0d exp=%0d", acc, exp_acc); end
        checks++; if ({carry, borrow, zero} !== {2'b01, exp_zero}) begin failures++; $display("FAIL borrow_flags got=%b exp=01%b", {carry, borrow, zero}, exp_zero); end
        checks++; if (n_ops !== 8'd7) begin failures++; $display("FAIL borrow_nops got=%0d exp=7", n_ops); end
        step();
    endtask

    task automatic test_back_to_back_stall();
        out_ready = 1'b0;
        send(1'b0, 8'd5);
`ifdef ACUMULADOR_SATURACAO_EN
        exp_acc = 8'd5;
`else
        exp_acc = 8'd4;
`endif
        checks++; if (acc !== exp_acc) begin failures++; $display("FAIL stall_acc got=%0d exp=%0d", acc, exp_acc); end
        in_valid = 1'b1; op = 1'b0; dado = 8'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || acc !== exp_acc || n_ops !== 8'd8) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got ov/ir=%b acc=%0d nops=%0d exp ov/ir=10 acc=%0d nops=8",
                         i, {out_valid, in_ready}, acc, n_ops, exp_acc);
            end
        end
        out_ready = 1'b1; in_valid = 1'b0;
        step();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL stall_release got=%b exp=10", {in_ready, out_valid}); end
        checks++; if (n_ops !== 8'd8 || acc !== exp_acc) begin failures++; $display("FAIL stall_noop got acc=%0d nops=%0d exp acc=%0d nops=8", acc, n_ops, exp_acc); end
    endtask

    task automatic test_clr();
        in_valid = 1'b1; op = 1'b0; dado = 8'd3;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        step();
        checks++; if (acc !== 8'd0 || n_ops !== 8'd0) begin failures++; $display("FAIL clr_state got acc=%0d nops=%0d exp 0/0", acc, n_ops); end
        checks++; if ({carry, borrow, zero} !== 3'b000) begin failures++; $display("FAIL clr_flags got=%b exp=000", {carry, borrow, zero}); end
        checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL clr_idle got=%b exp=10", {in_ready, out_valid}); end
        clr = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        send(1'b0, 8'd9);
        checks++; if (acc !== 8'd9 || n_ops !== 8'd1) begin failures++; $display("FAIL pre_rst_op got acc=%0d nops=%0d exp 9/1", acc, n_ops); end
        rst_n = 1'b0; clr = 1'b1;
        step();
        checks++; if (acc !== 8'd0 || n_ops !== 8'd0) begin failures++; $display("FAIL rstmid_state got acc=%0d nops=%0d exp 0/0", acc, n_ops); end
        checks++; if ({carry, borrow, zero, out_valid} !== 4'b0010) begin failures++; $display("FAIL rstmid_flags got=%b exp=0010", {carry, borrow, zero, out_valid}); end
        rst_n = 1'b1; clr = 1'b0; out_ready = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ir got=%b exp=1", in_ready); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            send(1'b0, 8'd0);
            if (i == 254) begin
                checks++; if (n_ops !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", n_ops); end
            end
            step();
        end
        checks++; if (n_ops !== 8'd0) begin failures++; $display("FAIL wrap_nops got=%0d exp=0", n_ops); end
        checks++; if (acc !== 8'd0 || zero !== 1'b1) begin failures++; $display("FAIL wrap_acc got acc=%0d zero=%b exp 0/1", acc, zero); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub_borrow();
        test_back_to_back_stall();
        test_clr();
        test_rst_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
